// File: rtl/encoder_sampler.sv
// Periodic quadrature-count sampler: produces a signed velocity per PERIOD-cycle window and an accumulated position.
// Optional position saturation with an at_limit flag is enabled by defining ENC_LIMIT_EN.
module encoder_sampler #(
    parameter int unsigned PERIOD    = 1000,
    parameter int unsigned POS_LIMIT = 30000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  count,
    input  logic        zero,
    input  logic        vel_ready,
    output logic        vel_valid,
    output logic [7:0]  velocity,
    output logic [15:0] position,
`ifdef ENC_LIMIT_EN
    output logic        at_limit,
`endif
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(PERIOD - 1);

    if (PERIOD < 2 || PERIOD > 65535 || POS_LIMIT < 1 || POS_LIMIT > 32767) begin : g_bad_params
        $error("encoder_sampler: PERIOD or POS_LIMIT out of range");
    end

    state_t      state;
    state_t      state_next;
    logic [15:0] timer;
    logic [7:0]  last_count;
    logic [7:0]  delta;
    logic [15:0] position_next;
    logic        load_base;
    logic        sample;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = ARM;
            ARM:     state_next = enable ? RUN : IDLE;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A window only closes while enable is still high; dropping enable abandons it.
    always_comb begin
        load_base = 1'b0;
        sample    = 1'b0;
        case (state)
            ARM:     load_base = 1'b1;
            RUN:     sample    = enable && (timer == TIMER_LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (state == RUN && enable && timer != TIMER_LAST) begin
            timer <= timer + 16'd1;
        end else begin
            timer <= '0;
        end
    end

    // Modular difference read as two's complement handles counter wrap in either direction.
    assign delta = count - last_count;

`ifdef ENC_LIMIT_EN
    localparam logic signed [16:0] LIM_HI = 17'(POS_LIMIT);
    localparam logic signed [16:0] LIM_LO = -LIM_HI;

    logic signed [16:0] pos_sum;

    always_comb begin
        pos_sum = zero ? 17'sd0 : $signed({position[15], position});
        if (sample) begin
            pos_sum = pos_sum + $signed({{9{delta[7]}}, delta});
        end
        if (pos_sum > LIM_HI) begin
            position_next = LIM_HI[15:0];
        end else if (pos_sum < LIM_LO) begin
            position_next = LIM_LO[15:0];
        end else begin
            position_next = pos_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            at_limit <= 1'b0;
        end else begin
            at_limit <= (position_next == LIM_HI[15:0]) || (position_next == LIM_LO[15:0]);
        end
    end
`else
    always_comb begin
        position_next = zero ? 16'd0 : position;
        if (sample) begin
            position_next = position_next + {{8{delta[7]}}, delta};
        end
    end
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_count <= '0;
            velocity   <= '0;
            position   <= '0;
            vel_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            position <= position_next;
            if (load_base || sample) begin
                last_count <= count;
            end
            if (sample) begin
                velocity <= delta;
            end
            if (sample) begin
                vel_valid <= 1'b1;
            end else if (vel_ready) begin
                vel_valid <= 1'b0;
            end
            if (zero) begin
                overrun <= 1'b0;
            end else if (sample && vel_valid && !vel_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
